store_merger: RTL

- Store-side counterpart of the load truncation/sign-extension unit.
- Takes a byte, halfword or word store request with a byte address and writes it into word-wide data memory.
- Sub-word stores use read-modify-write: read the word, merge the addressed lane(s), write it back.
- Sits between the MEM stage and data memory; the unit is idle unless a store is issued.

---
 rtl/store_merger_if.sv | 49 ++++
 rtl/store_merger.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/store_merger_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// store_merger_if
// Bundles the store request handshake and the data-memory bus of
// store_merger.
//
// Handshake: a request moves on a rising clock edge where I_STM_valid and
// O_STM_ready are both 1. The requester may raise valid at any time and must
// not rely on the unit sampling addr/data/size except at that accept edge.
// Completion is a one-cycle O_STM_done pulse, and O_STM_misaligned qualifies
// it. No backpressure exists on the memory side. A read returns data on
// I_STM_mem_rdata READ_LAT cycles after the O_STM_mem_rd_en cycle.
//
// Signals
//   I_STM_valid / O_STM_ready   request handshake
//   I_STM_addr / _data / _size  store request payload
//   O_STM_done / _misaligned    completion pulse and reject flag
//   O_STM_mem_*                 word-wide data memory port
//   I_STM_mem_rdata             memory read data
// Modports: slave = store_merger side, master = requester and memory side.
// ---------------------------------------------------------------------------
interface store_merger_if #(
   parameter int ADDR_W = 32
);
   logic              I_STM_valid;
   logic              O_STM_ready;
   logic [ADDR_W-1:0] I_STM_addr;
   logic [31:0]       I_STM_data;
   logic [1:0]        I_STM_size;
   logic              O_STM_done;
   logic              O_STM_misaligned;
   logic [ADDR_W-3:0] O_STM_mem_addr;
   logic              O_STM_mem_rd_en;
   logic [31:0]       I_STM_mem_rdata;
   logic              O_STM_mem_wr_en;
   logic [31:0]       O_STM_mem_wdata;

   modport slave (
      input  I_STM_valid, I_STM_addr, I_STM_data, I_STM_size, I_STM_mem_rdata,
      output O_STM_ready, O_STM_done, O_STM_misaligned, O_STM_mem_addr,
             O_STM_mem_rd_en, O_STM_mem_wr_en, O_STM_mem_wdata
   );

   modport master (
      output I_STM_valid, I_STM_addr, I_STM_data, I_STM_size, I_STM_mem_rdata,
      input  O_STM_ready, O_STM_done, O_STM_misaligned, O_STM_mem_addr,
             O_STM_mem_rd_en, O_STM_mem_wr_en, O_STM_mem_wdata
   );
endinterface

// File: rtl/store_merger.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// store_merger
// This unit performs the store side of the MEM stage. It writes a byte,
// halfword or word store into a word-wide data memory. A sub-word store uses
// read-modify-write: read the word, replace the addressed lane(s), write it
// back. An aligned word store writes directly. A misaligned or illegal-size
// request is rejected with done+misaligned and causes no memory traffic.
//
// Ports
//   I_STM_clk        rising-edge clock
//   I_STM_rst_n      asynchronous active-low reset
//   bus              store_merger_if.slave (request handshake + memory port)
//   O_STM_dbg_state  current FSM state, for observation only
//
// Parameters
//   ADDR_W    byte-address width (memory word address is ADDR_W-2 bits)
//   READ_LAT  memory read latency in cycles, >= 1
// ---------------------------------------------------------------------------
module store_merger #(
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic                 I_STM_clk,
   input  logic                 I_STM_rst_n,
   store_merger_if.slave        bus,
   output logic [2:0]           O_STM_dbg_state
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // The wait counter counts 0 .. READ_LAT-1. The final count is the edge on
   // which the memory's read data is valid.
   localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        size_q, size_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              ready_q, done_q, mis_q, rd_q, wr_q;

   // Replaces the addressed lane(s) of the old word with the store data.
   // The word is little-endian: byte lane k is bits [8k+7:8k].
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] st_d,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane);
      logic [31:0] r;
      r = old_w;
      case (sz)
         SZ_BYTE: begin
            case (lane)
               2'b00:   r[7:0]   = st_d[7:0];
               2'b01:   r[15:8]  = st_d[7:0];
               2'b10:   r[23:16] = st_d[7:0];
               default: r[31:24] = st_d[7:0];
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) r[31:16] = st_d[15:0];
            else         r[15:0]  = st_d[15:0];
         end
         default: r = st_d;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Next-state logic and request latching
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            // ready is high exactly in IDLE, so valid here is an accept.
            if (bus.I_STM_valid) begin
               addr_d = bus.I_STM_addr;
               data_d = bus.I_STM_data;
               size_d = bus.I_STM_size;
               if (bus.I_STM_size == SZ_WORD && bus.I_STM_addr[1:0] == 2'b00) begin
                  state_d = S_WRITE;
               end else if (bus.I_STM_size == SZ_BYTE ||
                            (bus.I_STM_size == SZ_HALF && !bus.I_STM_addr[0])) begin
                  state_d = S_READ;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_READ: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               rdata_d = bus.I_STM_mem_rdata;
               state_d = S_WRITE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers. The strobes decode the next state and
   // are registered here, so they line up with the state they belong to
   // and are glitch-free at the memory.
   // ------------------------------------------------------------------
   always_ff @(posedge I_STM_clk or negedge I_STM_rst_n) begin
      if (!I_STM_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         rdata_q <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         rdata_q <= rdata_d;
         ready_q <= (state_d == S_IDLE);
         done_q  <= (state_d == S_WRITE) || (state_d == S_ERR);
         mis_q   <= (state_d == S_ERR);
         rd_q    <= (state_d == S_READ);
         wr_q    <= (state_d == S_WRITE);
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.O_STM_ready      = ready_q;
   assign bus.O_STM_done       = done_q;
   assign bus.O_STM_misaligned = mis_q;
   assign bus.O_STM_mem_rd_en  = rd_q;
   assign bus.O_STM_mem_wr_en  = wr_q;
   // The word address comes straight from the latched byte address, so it
   // holds from READ through WRITE and keeps its last value in IDLE.
   assign bus.O_STM_mem_addr   = addr_q[ADDR_W-1:2];
   // The write data comes from registers only: the latched request and the
   // captured read word. For a word store the merge returns the store data
   // unchanged, and no read is needed.
   assign bus.O_STM_mem_wdata  = merge_lanes(rdata_q, data_q, size_q, addr_q[1:0]);

   assign O_STM_dbg_state      = state_q;

endmodule
